// File: rtl/imm_extend_pipe.sv
// Decode-stage immediate extender: forms I/S/B/J/U/zimm immediates, extends to XLEN,
// and holds results with a tag in a two-slot elastic buffer (head + skid).
//
//  state | meaning
//  EMPTY | no entry held, out_valid low
//  ONE   | head slot holds the oldest entry
//  FULL  | head and skid both hold entries, in_ready low
module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} bufState_e;

  bufState_e        state;
  logic             rdyQ;
  logic [XLEN-1:0]  headImm, skidImm;
  logic [TAG_W-1:0] headTag, skidTag;
  logic             headIll, skidIll;

  logic [31:0]      imm32;
  logic             newIll;
  logic [XLEN-1:0]  newImm;
  logic             accept, retire, sgn;

  // instr[k] carries instruction bit k+7
  assign sgn = instr[24];

  always_comb begin
    imm32  = '0;
    newIll = 1'b0;
    case (imm_src)
      3'b000:  imm32 = {{20{sgn}}, instr[24:13]};
      3'b001:  imm32 = {{20{sgn}}, instr[24:18], instr[4:0]};
      3'b010:  imm32 = {{20{sgn}}, instr[0], instr[23:18], instr[4:1], 1'b0};
      3'b011:  imm32 = {{12{sgn}}, instr[12:5], instr[13], instr[23:14], 1'b0};
      3'b100:  imm32 = {instr[24:5], 12'b0};
      3'b101:  imm32 = {27'b0, instr[12:8]};
      default: newIll = 1'b1;
    endcase
  end

  // zimm and reserved leave bit 31 clear, so sign replication is correct for every format
  generate
    if (XLEN > 32) begin : gWide
      assign newImm = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : gNarrow
      assign newImm = imm32;
    end
  endgenerate

  assign out_valid = (state != EMPTY);
  assign in_ready  = rdyQ;
  assign accept    = in_valid & rdyQ;
  assign retire    = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= EMPTY;
      rdyQ    <= 1'b0;
      headImm <= '0;
      headTag <= '0;
      headIll <= 1'b0;
    end else if (flush) begin
      state <= EMPTY;
      rdyQ  <= 1'b1;
    end else begin
      rdyQ <= 1'b1;
      case (state)
        EMPTY: begin
          if (accept) begin
            state   <= ONE;
            headImm <= newImm;
            headTag <= in_tag;
            headIll <= newIll;
          end
        end
        ONE: begin
          if (accept && !retire) begin
            state <= FULL;
            rdyQ  <= 1'b0;
          end else if (retire && !accept) begin
            state <= EMPTY;
          end else if (accept && retire) begin
            headImm <= newImm;
            headTag <= in_tag;
            headIll <= newIll;
          end
        end
        FULL: begin
          if (retire) begin
            state   <= ONE;
            headImm <= skidImm;
            headTag <= skidTag;
            headIll <= skidIll;
          end else begin
            rdyQ <= 1'b0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Skid slot is only read after a write into it, so it carries no reset
  always_ff @(posedge clk) begin
    if (!flush && state == ONE && accept && !retire) begin
      skidImm <= newImm;
      skidTag <= in_tag;
      skidIll <= newIll;
    end
  end

  assign imm_ext     = headImm;
  assign out_tag     = headTag;
  assign out_illegal = headIll;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: one 32-bit and one 64-bit instance share stimulus
// and are checked against hand-computed immediates, tags and handshake values.
`timescale 1ns/100ps
module tb_imm_extend_pipe;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] w;
    logic [31:0] e;
    logic [4:0]  tag;
    logic        ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, out_ready;
  logic [24:0] instr;
  logic [2:0]  imm_src;
  logic [4:0]  in_tag;

  logic        inReady32, outValid32, ill32;
  logic [31:0] imm32o;
  logic [4:0]  tag32;
  logic        inReady64, outValid64, ill64;
  logic [63:0] imm64o;
  logic [4:0]  tag64;

  int nCompared = 0;
  int nMismatch = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(inReady32),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(outValid32),
    .out_ready(out_ready), .imm_ext(imm32o), .out_tag(tag32), .out_illegal(ill32)
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(inReady64),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(outValid64),
    .out_ready(out_ready), .imm_ext(imm64o), .out_tag(tag64), .out_illegal(ill64)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkOut(input string name, input logic [31:0] e, input logic [4:0] t,
                          input logic ill);
    checkVal({name, "_v32"}, {63'b0, outValid32}, 64'd1);
    checkVal({name, "_v64"}, {63'b0, outValid64}, 64'd1);
    checkVal({name, "_imm32"}, {32'b0, imm32o}, {32'b0, e});
    checkVal({name, "_imm64"}, imm64o, {{32{e[31]}}, e});
    checkVal({name, "_tag32"}, {59'b0, tag32}, {59'b0, t});
    checkVal({name, "_tag64"}, {59'b0, tag64}, {59'b0, t});
    checkVal({name, "_ill32"}, {63'b0, ill32}, {63'b0, ill});
    checkVal({name, "_ill64"}, {63'b0, ill64}, {63'b0, ill});
  endtask

  task automatic checkIdle(input string name);
    checkVal({name, "_nv32"}, {63'b0, outValid32}, 64'd0);
    checkVal({name, "_nv64"}, {63'b0, outValid64}, 64'd0);
  endtask

  task automatic checkRdy(input string name, input logic exp);
    checkVal({name, "_rdy32"}, {63'b0, inReady32}, {63'b0, exp});
    checkVal({name, "_rdy64"}, {63'b0, inReady64}, {63'b0, exp});
  endtask

  task automatic drive(input logic [2:0] src, input logic [31:0] w, input logic [4:0] tag);
    in_valid = 1'b1;
    imm_src  = src;
    instr    = w[31:7];
    in_tag   = tag;
  endtask

  task automatic addVec(input logic [2:0] src, input logic [31:0] w, input logic [31:0] e,
                        input logic [4:0] tag, input logic ill);
    vec_t v;
    v.src = src; v.w = w; v.e = e; v.tag = tag; v.ill = ill;
    vecs.push_back(v);
  endtask

  // Streams the vector queue back to back with out_ready high; called at a negedge
  task automatic streamVecs(input string name);
    int n;
    n = vecs.size();
    for (int i = 0; i <= n; i++) begin
      if (i > 0) checkOut($sformatf("%s_%0d", name, i - 1), vecs[i-1].e, vecs[i-1].tag, vecs[i-1].ill);
      if (i < n) begin
        checkRdy($sformatf("%s_in%0d", name, i), 1'b1);
        drive(vecs[i].src, vecs[i].w, vecs[i].tag);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    checkIdle({name, "_drain"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; imm_src = '0; in_tag = '0;
    repeat (2) @(negedge clk);
    checkIdle("rst");
    checkRdy("rst", 1'b0);
    checkVal("rst_imm64", imm64o, 64'd0);
    checkVal("rst_tag32", {59'b0, tag32}, 64'd0);
    checkVal("rst_ill32", {63'b0, ill32}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkRdy("post_rst", 1'b1);
    checkIdle("post_rst");

    // Format sweep, including reserved sources followed by a legal entry
    addVec(3'b000, 32'hFFF0_0000, 32'hFFFF_FFFF, 5'd1,  1'b0);
    addVec(3'b000, 32'h7FF0_0000, 32'h0000_07FF, 5'd2,  1'b0);
    addVec(3'b001, 32'h0200_0080, 32'h0000_0021, 5'd3,  1'b0);
    addVec(3'b001, 32'hFE00_0F80, 32'hFFFF_FFFF, 5'd4,  1'b0);
    addVec(3'b010, 32'h8000_0080, 32'hFFFF_F800, 5'd5,  1'b0);
    addVec(3'b010, 32'h7E00_0F00, 32'h0000_07FE, 5'd6,  1'b0);
    addVec(3'b011, 32'h8000_0000, 32'hFFF0_0000, 5'd7,  1'b0);
    addVec(3'b011, 32'h7FFF_F000, 32'h000F_FFFE, 5'd8,  1'b0);
    addVec(3'b100, 32'h8765_4FFF, 32'h8765_4000, 5'd9,  1'b0);
    addVec(3'b101, 32'hFFFF_FFFF, 32'h0000_001F, 5'd10, 1'b0);
    addVec(3'b101, 32'h0005_0000, 32'h0000_000A, 5'd11, 1'b0);
    addVec(3'b110, 32'hFFFF_FF80, 32'h0000_0000, 5'd12, 1'b1);
    addVec(3'b000, 32'h0010_0000, 32'h0000_0001, 5'd13, 1'b0);
    addVec(3'b111, 32'h1234_5678, 32'h0000_0000, 5'd14, 1'b1);
    streamVecs("sweep");

    // Sustained accept-and-retire in ONE
    vecs.delete();
    for (int k = 1; k <= 11; k++)
      addVec(3'b000, 32'(k) << 20, 32'(k), 5'(k + 16), 1'b0);
    streamVecs("steady");

    // Back-pressure: third push is refused until the head drains
    out_ready = 1'b0;
    drive(3'b000, 32'h0010_0000, 5'd1);
    @(negedge clk);
    checkRdy("bp1", 1'b1);
    drive(3'b000, 32'h0020_0000, 5'd2);
    @(negedge clk);
    checkRdy("bp_full", 1'b0);
    checkOut("bp_head", 32'd1, 5'd1, 1'b0);
    drive(3'b000, 32'h0030_0000, 5'd3);
    @(negedge clk);
    checkRdy("bp_hold", 1'b0);
    checkOut("bp_stable", 32'd1, 5'd1, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    checkRdy("bp_rel", 1'b1);
    checkOut("bp_t2", 32'd2, 5'd2, 1'b0);
    @(negedge clk);
    checkOut("bp_t3", 32'd3, 5'd3, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    checkIdle("bp_end");

    // Flush from FULL with a simultaneous push
    out_ready = 1'b0;
    drive(3'b000, 32'h0040_0000, 5'd4);
    @(negedge clk);
    drive(3'b000, 32'h0050_0000, 5'd5);
    @(negedge clk);
    checkRdy("fl_full", 1'b0);
    flush = 1'b1;
    drive(3'b000, 32'h0090_0000, 5'd9);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checkIdle("fl_full_after");
    checkRdy("fl_full_after", 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    checkIdle("fl_full_later");

    // Flush from ONE while an accept would otherwise happen
    out_ready = 1'b0;
    drive(3'b000, 32'h0060_0000, 5'd6);
    @(negedge clk);
    checkOut("fl_one_head", 32'd6, 5'd6, 1'b0);
    flush = 1'b1;
    drive(3'b000, 32'h0070_0000, 5'd7);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checkIdle("fl_one_after");
    @(negedge clk);
    checkIdle("fl_one_later");
    out_ready = 1'b1;
    drive(3'b000, 32'h0080_0000, 5'd8);
    @(negedge clk);
    checkOut("fl_clean", 32'd8, 5'd8, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    checkIdle("fl_clean_end");

    // Asynchronous reset pulse while FULL
    out_ready = 1'b0;
    drive(3'b000, 32'h00B0_0000, 5'd11);
    @(negedge clk);
    drive(3'b000, 32'h00C0_0000, 5'd12);
    @(negedge clk);
    in_valid = 1'b0;
    checkRdy("ar_full", 1'b0);
    #2 reset_n = 1'b0;
    #0.5;
    checkIdle("ar_low");
    checkRdy("ar_low", 1'b0);
    #0.5 reset_n = 1'b1;
    #0.5;
    checkIdle("ar_rel");
    checkVal("ar_imm64", imm64o, 64'd0);
    checkVal("ar_tag64", {59'b0, tag64}, 64'd0);
    @(negedge clk);
    checkRdy("ar_rdy", 1'b1);
    checkIdle("ar_rdy");
    out_ready = 1'b1;
    drive(3'b100, 32'h1234_5000, 5'd13);
    @(negedge clk);
    checkOut("ar_first", 32'h1234_5000, 5'd13, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    checkIdle("ar_nostale");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
